// File: rtl/input_data_info_reader.sv
// Read-domain consumer of the packet descriptor FIFO.
// Pops one descriptor at a time, raises a valid/ready allocation request
// toward the shared-cache scheduler, and then paces the matching number of
// cell reads out of the input data FIFO, marking the final cell.
module input_data_info_reader #(
  parameter int PORT_NUB_TOTAL         = 16,
  parameter int PRI_NUM                = 8,
  parameter int DATABUF_HIGH_LIMIT_NUM = 64,
  parameter int CRC32_LENGTH_WIDTH     = 11,
  parameter int PW                     = $clog2(PORT_NUB_TOTAL),
  parameter int QW                     = $clog2(PRI_NUM),
  parameter int CW                     = $clog2(DATABUF_HIGH_LIMIT_NUM),
  parameter int LW                     = CRC32_LENGTH_WIDTH,
  parameter int DATA_BIT               = PW + QW + CW + LW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_BIT-1:0] info_rd_data,
  input  logic                info_empty,
  output logic                info_rd_en,
  output logic                req_valid,
  input  logic                req_ready,
  output logic [PW-1:0]       req_port,
  output logic [QW-1:0]       req_pri,
  output logic [CW-1:0]       req_cells,
  output logic [LW-1:0]       req_len,
  input  logic                data_empty,
  input  logic                cell_ready,
  output logic                cell_rd_en,
  output logic                cell_last,
  output logic                busy,
  output logic                drop_pulse,
  output logic [15:0]         drop_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } state_t;

  state_t        state;

  // Descriptor fields held for the request; one stage after the pop.
  logic [PW-1:0] port_p1;
  logic [QW-1:0] pri_p1;
  logic [CW-1:0] cells_p1;
  logic [LW-1:0] len_p1;

  // Cells still to be read for the packet in flight.
  logic [CW-1:0] rem_p1;
  logic          drop_pulse_p1;
  logic [15:0]   drop_cnt_p1;

  // Head-of-FIFO descriptor decode, MSB to LSB: port, pri, cells, len.
  logic [PW-1:0] dec_port;
  logic [QW-1:0] dec_pri;
  logic [CW-1:0] dec_cells;
  logic [LW-1:0] dec_len;

  assign {dec_port, dec_pri, dec_cells, dec_len} = info_rd_data;

  // Saturating increment for the discard counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Pop strobe and cell strobe are combinational so a ready FIFO or a ready
  // cache write path is serviced in the same cycle. The pop is also held off
  // while reset is asserted so every output reads zero during reset.
  assign info_rd_en = rst_n & (state == IDLE) & ~info_empty;
  assign cell_rd_en = (state == XFER) & ~data_empty & cell_ready;
  assign cell_last  = cell_rd_en & (rem_p1 == CW'(1));

  assign req_valid  = (state == REQ);
  assign busy       = (state != IDLE);
  assign req_port   = port_p1;
  assign req_pri    = pri_p1;
  assign req_cells  = cells_p1;
  assign req_len    = len_p1;
  assign drop_pulse = drop_pulse_p1;
  assign drop_cnt   = drop_cnt_p1;

  // Packet sequencing: pop/decode, request handshake, then cell pacing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      port_p1       <= '0;
      pri_p1        <= '0;
      cells_p1      <= '0;
      len_p1        <= '0;
      rem_p1        <= '0;
      drop_pulse_p1 <= 1'b0;
      drop_cnt_p1   <= '0;
    end else begin
      drop_pulse_p1 <= 1'b0;
      unique case (state)
        IDLE: begin
          if (info_rd_en) begin
            port_p1  <= dec_port;
            pri_p1   <= dec_pri;
            cells_p1 <= dec_cells;
            len_p1   <= dec_len;
            // A zero-cell descriptor cannot be allocated; discard it here.
            if (dec_cells != '0) begin
              state <= REQ;
            end else begin
              drop_pulse_p1 <= 1'b1;
              drop_cnt_p1   <= sat_inc16(drop_cnt_p1);
            end
          end
        end
        REQ: begin
          if (req_ready) begin
            rem_p1 <= cells_p1;
            state  <= XFER;
          end
        end
        XFER: begin
          // rem is loaded with at least 1, so it never wraps below zero.
          if (cell_rd_en) begin
            rem_p1 <= rem_p1 - CW'(1);
            if (rem_p1 == CW'(1)) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_input_data_info_reader.sv
// Directed bench for input_data_info_reader with a queue-modelled info FIFO.
module tb_input_data_info_reader;

  localparam int PW = 4;
  localparam int QW = 3;
  localparam int CW = 6;
  localparam int LW = 11;
  localparam int DB = PW + QW + CW + LW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DB-1:0] info_rd_data;
  logic          info_empty;
  logic          info_rd_en;
  logic          req_valid;
  logic          req_ready;
  logic [PW-1:0] req_port;
  logic [QW-1:0] req_pri;
  logic [CW-1:0] req_cells;
  logic [LW-1:0] req_len;
  logic          data_empty;
  logic          cell_ready;
  logic          cell_rd_en;
  logic          cell_last;
  logic          busy;
  logic          drop_pulse;
  logic [15:0]   drop_cnt;

  input_data_info_reader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .info_rd_data (info_rd_data),
    .info_empty   (info_empty),
    .info_rd_en   (info_rd_en),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_port     (req_port),
    .req_pri      (req_pri),
    .req_cells    (req_cells),
    .req_len      (req_len),
    .data_empty   (data_empty),
    .cell_ready   (cell_ready),
    .cell_rd_en   (cell_rd_en),
    .cell_last    (cell_last),
    .busy         (busy),
    .drop_pulse   (drop_pulse),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  logic [DB-1:0] fifo_q[$];
  bit            flood;

  int n_cmp;
  int n_bad;

  // Per-run observations.
  int            idx;
  logic [63:0]   h_ird, h_rv, h_crd, h_cl, h_busy, h_drop;
  int            n_ird, n_rv, n_crd, n_cl, n_drop;
  int            last_cl, fld_bad, strobe_bad, ird_bad;
  logic          prev_rv;
  logic [DB-1:0] cap;

  function automatic logic [DB-1:0] mk(input int port, input int pri, input int cells, input int len);
    logic [PW-1:0] p;
    logic [QW-1:0] q;
    logic [CW-1:0] c;
    logic [LW-1:0] l;
    p = PW'(port);
    q = QW'(pri);
    c = CW'(cells);
    l = LW'(len);
    mk = {p, q, c, l};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    idx = 0;
    h_ird = '0; h_rv = '0; h_crd = '0; h_cl = '0; h_busy = '0; h_drop = '0;
    n_ird = 0; n_rv = 0; n_crd = 0; n_cl = 0; n_drop = 0;
    last_cl = -1; fld_bad = 0; strobe_bad = 0; ird_bad = 0;
    prev_rv = 1'b0;
    cap = '0;
  endtask

  // One clock cycle: present the FIFO head, sample outputs, model the pop.
  task automatic cyc();
    if (flood) begin
      info_empty   = 1'b0;
      info_rd_data = mk(0, 0, 0, 0);
    end else begin
      info_empty   = (fifo_q.size() == 0);
      info_rd_data = info_empty ? '0 : fifo_q[0];
    end
    #1;
    if (idx < 64) begin
      h_ird[idx]  = info_rd_en;
      h_rv[idx]   = req_valid;
      h_crd[idx]  = cell_rd_en;
      h_cl[idx]   = cell_last;
      h_busy[idx] = busy;
      h_drop[idx] = drop_pulse;
    end
    n_ird  += int'(info_rd_en);
    n_rv   += int'(req_valid);
    n_crd  += int'(cell_rd_en);
    n_cl   += int'(cell_last);
    n_drop += int'(drop_pulse);
    if (cell_last) last_cl = idx;
    if (cell_rd_en && (data_empty || !cell_ready)) strobe_bad++;
    if (info_rd_en && busy) ird_bad++;
    if (req_valid && !prev_rv) cap = {req_port, req_pri, req_cells, req_len};
    else if (req_valid && ({req_port, req_pri, req_cells, req_len} != cap)) fld_bad++;
    prev_rv = req_valid;
    if (info_rd_en && !flood && fifo_q.size() > 0) void'(fifo_q.pop_front());
    idx++;
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, 64'({info_rd_en, req_valid, req_port, req_pri, req_cells, req_len,
                  cell_rd_en, cell_last, busy, drop_pulse, drop_cnt}), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0; n_bad = 0; flood = 0;
    rst_n = 1'b0; info_empty = 1'b1; info_rd_data = '0;
    req_ready = 1'b1; data_empty = 1'b0; cell_ready = 1'b1;
    clr();
    @(negedge clk);
    @(negedge clk);
    chk_zero("reset_outputs");
    rst_n = 1'b1;

    // Basic packet, everything ready.
    fifo_q.push_back(mk(3, 5, 4, 200));
    clr();
    repeat (8) cyc();
    chk("t1_info_rd_en", h_ird, 64'h1);
    chk("t1_req_valid", h_rv, 64'h2);
    chk("t1_fields", 64'(cap), 64'(mk(3, 5, 4, 200)));
    chk("t1_cell_rd_en", h_crd, 64'h3C);
    chk("t1_cell_last", h_cl, 64'h20);
    chk("t1_busy", h_busy, 64'h3E);

    // Scheduler holds off the request for 10 cycles.
    fifo_q.push_back(mk(3, 5, 4, 200));
    clr();
    for (int i = 0; i < 20; i++) begin
      req_ready = (i >= 11);
      cyc();
    end
    chk("t2_req_valid", h_rv, 64'h0FFE);
    chk("t2_field_stable", fld_bad, 0);
    chk("t2_fields", 64'(cap), 64'(mk(3, 5, 4, 200)));
    chk("t2_cell_rd_en", h_crd, 64'hF000);
    chk("t2_cell_last", h_cl, 64'h8000);

    // Data FIFO toggling empty and cache write path stalled mid-packet.
    fifo_q.push_back(mk(7, 2, 3, 96));
    clr();
    for (int i = 0; i < 16; i++) begin
      data_empty = (i >= 2) && ((i - 2) % 2 == 0);
      cell_ready = !(i >= 4 && i < 9);
      cyc();
    end
    data_empty = 1'b0;
    cell_ready = 1'b1;
    chk("t3_cell_rd_en", h_crd, 64'hA08);
    chk("t3_cell_last", h_cl, 64'h800);
    chk("t3_strobe_gated", strobe_bad, 0);
    chk("t3_busy_end", h_busy[15:12], 64'h0);

    // Two queued descriptors: one cell, then the maximum cell count.
    fifo_q.push_back(mk(1, 0, 1, 10));
    fifo_q.push_back(mk(15, 7, 63, 2047));
    clr();
    repeat (70) cyc();
    chk("t4_info_rd_en", h_ird, 64'h9);
    chk("t4_req_count", n_rv, 2);
    chk("t4_fields2", 64'(cap), 64'(mk(15, 7, 63, 2047)));
    chk("t4_cells_total", n_crd, 64);
    chk("t4_last_count", n_cl, 2);
    chk("t4_last_pos", last_cl, 67);
    chk("t4_pop_while_busy", ird_bad, 0);

    // Malformed zero-cell descriptor followed by a good one.
    fifo_q.push_back(mk(4, 4, 0, 100));
    fifo_q.push_back(mk(2, 1, 2, 64));
    clr();
    repeat (7) cyc();
    chk("t5_drop_pulse", h_drop, 64'h2);
    chk("t5_req_valid", h_rv, 64'h4);
    chk("t5_fields", 64'(cap), 64'(mk(2, 1, 2, 64)));
    chk("t5_cells", n_crd, 2);
    chk("t5_last_pos", last_cl, 4);
    chk("t5_drop_cnt", drop_cnt, 64'd1);

    // Drive the discard counter to saturation and beyond.
    clr();
    flood = 1;
    repeat (65534) cyc();
    flood = 0;
    cyc();
    chk("t5_drop_cnt_max", drop_cnt, 64'hFFFF);
    chk("t5_flood_no_req", n_rv, 0);
    clr();
    flood = 1;
    repeat (2) cyc();
    flood = 0;
    cyc();
    chk("t5_drop_cnt_sat", drop_cnt, 64'hFFFF);
    chk("t5_drop_pulses", n_drop, 2);

    // Reset in the middle of a transfer with five cells outstanding.
    fifo_q.push_back(mk(6, 3, 8, 500));
    fifo_q.push_back(mk(9, 2, 2, 33));
    clr();
    repeat (5) cyc();
    chk("t6_busy_before", busy, 64'd1);
    chk("t6_cells_before", n_crd, 3);
    cell_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_zero("t6_reset_async");
    @(negedge clk);
    chk_zero("t6_reset_held");
    rst_n = 1'b1;
    cell_ready = 1'b1;
    clr();
    repeat (6) cyc();
    chk("t6_info_rd_en", h_ird, 64'h1);
    chk("t6_fields", 64'(cap), 64'(mk(9, 2, 2, 33)));
    chk("t6_cells", n_crd, 2);
    chk("t6_last_pos", last_cl, 3);
    chk("t6_busy_end", busy, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/input_data_info_reader.md
Name: input_data_info_reader

Overview:
- Read-side consumer of the input data-info dual-clock FIFO. Runs in the FIFO read-clock domain.
- Pops one packet descriptor at a time and decodes it into destination port, priority, cell count and CRC32 length.
- Presents a valid/ready allocation request to the shared-cache scheduler.
- After the request is accepted, paces the matching number of cell reads out of the input data FIFO toward the cache write path, flagging the last cell.

Parameters:
- PORT_NUB_TOTAL, 16, number of switch ports; port field width PW = $clog2(PORT_NUB_TOTAL).
- PRI_NUM, 8, priority levels; priority field width QW = $clog2(PRI_NUM).
- DATABUF_HIGH_LIMIT_NUM, 64, max cells per packet; cell field width CW = $clog2(DATABUF_HIGH_LIMIT_NUM).
- CRC32_LENGTH_WIDTH, 11, width LW of the packet length field.
- DATA_BIT, PW+QW+CW+LW, descriptor width.

Ports:
- clk, input, 1, read-domain clock.
- rst_n, input, 1, asynchronous active-low reset.
- info_rd_data, input, DATA_BIT, descriptor at FIFO head; combinational, valid whenever info_empty=0.
- info_empty, input, 1, info FIFO empty.
- info_rd_en, output, 1, pops the head descriptor at the clock edge.
- req_valid, output, 1, allocation request valid.
- req_ready, input, 1, scheduler accepts the request.
- req_port, output, PW, destination port.
- req_pri, output, QW, priority.
- req_cells, output, CW, cell count.
- req_len, output, LW, packet length.
- data_empty, input, 1, input data FIFO empty.
- cell_ready, input, 1, cache write path can take a cell this cycle.
- cell_rd_en, output, 1, read strobe to data FIFO; one cell transferred per asserted cycle.
- cell_last, output, 1, qualifies the final cell_rd_en of the packet.
- busy, output, 1, FSM not in IDLE.
- drop_pulse, output, 1, one-cycle pulse when a malformed descriptor is discarded.
- drop_cnt, output, 16, saturating count of discarded descriptors.

Behaviour:
- Descriptor packing, MSB to LSB: port[PW], pri[QW], cells[CW], len[LW].
- Reset, asynchronous: state IDLE. All outputs 0, including req_* fields, drop_cnt and the internal remaining-cell counter rem. Reset mid-packet abandons the packet; any descriptor already popped is lost.
- FSM states: IDLE, REQ, XFER.
- IDLE:
  - info_rd_en = !info_empty (combinational).
  - On a pop, register the decoded fields.
  - If cells != 0: go to REQ next cycle.
  - If cells == 0: stay in IDLE, pulse drop_pulse in the following cycle, increment drop_cnt (saturate at 0xFFFF). No request is issued.
- REQ:
  - req_valid = 1; req_* fields come from registers and stay stable until the handshake.
  - On req_valid & req_ready: load rem = req_cells and go to XFER. req_valid deasserts in the next cycle.
  - Request latency is one cycle from the pop to req_valid.
- XFER:
  - cell_rd_en = !data_empty & cell_ready (combinational).
  - Each asserted cycle decrements rem.
  - cell_last = cell_rd_en & (rem == 1).
  - On cell_last, go to IDLE.
  - Stalls from data_empty or !cell_ready may last arbitrarily long; rem holds during stalls.
- info_rd_en is never asserted outside IDLE, so at most one descriptor is in flight. At least one IDLE cycle separates packets, so back-to-back throughput is N cells + 2 cycles per packet.
- Maximum cell count is DATABUF_HIGH_LIMIT_NUM-1 (all-ones field). rem is CW bits wide and does not wrap, because its minimum load value is 1.
- busy = (state != IDLE).
- No output depends combinationally on req_ready except the state transition itself.

Test Plan:
- Reset, then push descriptor port=3, pri=5, cells=4, len=200 with req_ready=1 and data always non-empty with cell_ready=1 → info_rd_en for 1 cycle, req_valid 1 cycle later for exactly 1 cycle with fields 3/5/4/200, then 4 consecutive cell_rd_en with cell_last on the 4th, then busy=0.
- Same descriptor, req_ready held low for 10 cycles → req_valid high and fields stable for 11 cycles; no cell_rd_en until after the handshake.
- cells=3 with data_empty toggling 1010… and cell_ready low for 5 cycles mid-packet → exactly 3 cell_rd_en, cell_last only on the 3rd, no strobe while empty or not ready.
- Two descriptors queued (cells=1, then cells=63) → second info_rd_en only after the first cell_last plus one IDLE cycle; 63 strobes total for the second, cell_last on the 63rd.
- Descriptor with cells=0 followed by a valid one → drop_pulse one cycle, drop_cnt=1, no req_valid for the bad entry; the valid one proceeds normally. Preload drop_cnt=0xFFFF → it stays 0xFFFF.
- Assert rst_n low mid-XFER with rem=5 → all outputs 0 immediately, state IDLE. After release, the next queued descriptor is processed from scratch.
